// File: rtl/sync_filter_pkg.sv
// ---------------------------------------------------------------------------
// sync_filter_pkg
//   Shared constants and helpers for the sync_filter block.
//   MIN_STAGES : smallest synchroniser depth that still resolves
//                metastability safely.
//   cnt_width  : width of the per-bit stability counter for a given
//                filter length. Returns max(1, clog2(filter_cycles + 1)).
// ---------------------------------------------------------------------------
package sync_filter_pkg;

    localparam int MIN_STAGES = 2;

    function automatic int cnt_width(input int filter_cycles);
        int w;
        w = $clog2(filter_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sync_filter_pkg

// File: rtl/sync_filter_bit.sv
// ---------------------------------------------------------------------------
// sync_filter_bit
//   One bit of sync_filter. It contains the flop chain, the optional
//   stability counter, the output level flop, the edge pulses and the
//   optional sticky flag.
//   Optional macro SYNC_FILTER_STICKY_EN adds i_sticky_clr / o_sticky.
//
// Ports
//   i_clk        : sole clock
//   i_rst_n      : asynchronous active-low reset
//   i_in         : asynchronous input bit
//   i_sticky_clr : clears o_sticky when sampled high (SYNC_FILTER_STICKY_EN)
//   o_sticky     : latched "an edge happened" flag    (SYNC_FILTER_STICKY_EN)
//   o_out        : synchronised, filtered level
//   o_rise       : one-cycle pulse when o_out goes 0->1
//   o_fall       : one-cycle pulse when o_out goes 1->0
// ---------------------------------------------------------------------------
module sync_filter_bit
    import sync_filter_pkg::*;
#(
    parameter int   STAGES        = MIN_STAGES,
    parameter logic DEFAULT_VAL   = 1'b0,
    parameter int   FILTER_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
`ifdef SYNC_FILTER_STICKY_EN
    input  logic i_sticky_clr,
    output logic o_sticky,
`endif
    output logic o_out,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] chain;
    logic              sync_s;
    logic              next_out;  // value o_out takes at the next edge

    // NOTE: every flop uses non-blocking assignment, so the shift below
    // moves each stage by exactly one position per edge regardless of
    // statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chain <= {STAGES{DEFAULT_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], i_in};
        end
    end

    assign sync_s = chain[STAGES-1];

    if (FILTER_CYCLES == 0) begin : g_bypass
        // The output is the last chain stage itself. The stage before it
        // holds the value that the output shows after the next edge. The
        // pulses use that value, so they appear in the same cycle as the
        // level change.
        assign o_out    = sync_s;
        assign next_out = chain[STAGES-2];
    end else begin : g_filter
        localparam int               CNT_W    = cnt_width(FILTER_CYCLES);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

        logic [CNT_W-1:0] cnt;
        logic             out_q;

        // NOTE: a combinational block assigns its default first. Then every
        // path drives next_out, and no latch is inferred.
        always_comb begin
            next_out = out_q;
            if ((sync_s != out_q) && (cnt == CNT_LAST)) begin
                next_out = sync_s;
            end
        end

        // The counter restarts whenever the synchronised value agrees with
        // the output again. It stops at CNT_LAST, so it cannot wrap.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt   <= '0;
                out_q <= DEFAULT_VAL;
            end else if (sync_s == out_q) begin
                cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                out_q <= sync_s;
            end else begin
                cnt   <= cnt + CNT_W'(1);
            end
        end

        assign o_out = out_q;
    end

    // The pulses compare the level that is about to commit with the
    // present level. Reset forces the present level to DEFAULT_VAL and
    // clears the pulse flops, so entering or leaving reset gives no pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            o_rise <= next_out & ~o_out;
            o_fall <= ~next_out & o_out;
        end
    end

`ifdef SYNC_FILTER_STICKY_EN
    // The flag sets on the same edge that raises a pulse. A set has
    // priority over a clear sampled on that edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sticky <= 1'b0;
        end else if (next_out != o_out) begin
            o_sticky <= 1'b1;
        end else if (i_sticky_clr) begin
            o_sticky <= 1'b0;
        end
    end
`endif

endmodule : sync_filter_bit

// File: rtl/sync_filter.sv
// ---------------------------------------------------------------------------
// sync_filter
//   Brings WIDTH independent asynchronous bits into the i_clk domain. Each
//   bit goes through a STAGES-deep flop chain. An optional per-bit
//   stability filter needs FILTER_CYCLES consecutive stable samples before
//   the output changes. Each bit also gives registered one-cycle rise and
//   fall pulses.
//   Optional macro SYNC_FILTER_STICKY_EN adds i_sticky_clr / o_sticky.
//
// Parameters
//   WIDTH         : number of independent bits
//   STAGES        : synchroniser depth, >= MIN_STAGES
//   DEFAULT       : reset value of the chain and of o_out
//   FILTER_CYCLES : stable samples needed before a change commits;
//                   0 bypasses the filter
//
// Ports
//   i_clk        : sole clock
//   i_rst_n      : asynchronous active-low reset
//   i_in         : asynchronous inputs
//   i_sticky_clr : per-bit sticky clear       (SYNC_FILTER_STICKY_EN)
//   o_sticky     : per-bit sticky edge flag   (SYNC_FILTER_STICKY_EN)
//   o_out        : synchronised, filtered level
//   o_rise       : one-cycle pulse per bit on 0->1
//   o_fall       : one-cycle pulse per bit on 1->0
// ---------------------------------------------------------------------------
module sync_filter
    import sync_filter_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter logic [WIDTH-1:0] DEFAULT       = '0,
    parameter int               FILTER_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in,
`ifdef SYNC_FILTER_STICKY_EN
    input  logic [WIDTH-1:0] i_sticky_clr,
    output logic [WIDTH-1:0] o_sticky,
`endif
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("sync_filter: STAGES must be at least 2");
    end

    if (FILTER_CYCLES < 0) begin : g_bad_filter
        $error("sync_filter: FILTER_CYCLES must not be negative");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_filter_bit #(
            .STAGES        (STAGES),
            .DEFAULT_VAL   (DEFAULT[i]),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_bit (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_in         (i_in[i]),
`ifdef SYNC_FILTER_STICKY_EN
            .i_sticky_clr (i_sticky_clr[i]),
            .o_sticky     (o_sticky[i]),
`endif
            .o_out        (o_out[i]),
            .o_rise       (o_rise[i]),
            .o_fall       (o_fall[i])
        );
    end

endmodule : sync_filter

// File: tb/tb_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_sync_filter
//   Directed bench with two instances:
//     u_filt : WIDTH=4, STAGES=2, DEFAULT=0, FILTER_CYCLES=4
//     u_byp  : WIDTH=4, STAGES=3, DEFAULT=0, FILTER_CYCLES=0
//   Inputs change and outputs are sampled 1 time unit after each rising
//   edge. "Edge k" counts from the first edge that samples a new input.
// ---------------------------------------------------------------------------
module tb_sync_filter;

    logic       clk;
    logic       rst_n;
    logic [3:0] a_in,  a_out, a_rise, a_fall;
    logic [3:0] b_in,  b_out, b_rise, b_fall;
    logic [3:0] a_clr, a_sticky, b_clr, b_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    sync_filter #(
        .WIDTH(4), .STAGES(2), .DEFAULT(4'h0), .FILTER_CYCLES(4)
    ) u_filt (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in         (a_in),
`ifdef SYNC_FILTER_STICKY_EN
        .i_sticky_clr (a_clr),
        .o_sticky     (a_sticky),
`endif
        .o_out        (a_out),
        .o_rise       (a_rise),
        .o_fall       (a_fall)
    );

    sync_filter #(
        .WIDTH(4), .STAGES(3), .DEFAULT(4'h0), .FILTER_CYCLES(0)
    ) u_byp (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in         (b_in),
`ifdef SYNC_FILTER_STICKY_EN
        .i_sticky_clr (b_clr),
        .o_sticky     (b_sticky),
`endif
        .o_out        (b_out),
        .o_rise       (b_rise),
        .o_fall       (b_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {out, rise, fall} so that one comparison covers one cycle.
    function automatic logic [31:0] pk(input logic [3:0] o, input logic [3:0] r,
                                       input logic [3:0] f);
        return {20'h0, o, r, f};
    endfunction

    initial begin
        a_in  = 4'hF;
        b_in  = 4'h0;
        a_clr = 4'h0;
        b_clr = 4'h0;
        rst_n = 1'b0;

        // Reset holds with the inputs differing from DEFAULT.
        tick();
        tick();
        check("reset_a", pk(a_out, a_rise, a_fall), pk(4'h0, 4'h0, 4'h0));
        check("reset_b", pk(b_out, b_rise, b_fall), pk(4'h0, 4'h0, 4'h0));
        rst_n = 1'b1;

        // Startup: output commits at edge 6 (2 stages + 4 samples).
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("startup_k%0d", k), pk(a_out, a_rise, a_fall),
                  pk((k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0));
        end

        // Asserting reset clears at once and gives no fall pulse.
        a_in  = 4'h0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_assert_async", pk(a_out, a_rise, a_fall), pk(4'h0, 4'h0, 4'h0));
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("idle_k%0d", k), pk(a_out, a_rise, a_fall), pk(4'h0, 4'h0, 4'h0));
        end

        // A 3-sample glitch on bit 0 is suppressed.
        a_in = 4'h1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) a_in = 4'h0;
            check($sformatf("glitch3_k%0d", k), pk(a_out, a_rise, a_fall), pk(4'h0, 4'h0, 4'h0));
        end

        // A 4-sample pulse on bit 0 passes: rise at edge 6, fall at edge 10.
        a_in = 4'h1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) a_in = 4'h0;
            check($sformatf("pulse4_k%0d", k), pk(a_out, a_rise, a_fall),
                  pk((k >= 6 && k < 10) ? 4'h1 : 4'h0,
                     (k == 6) ? 4'h1 : 4'h0,
                     (k == 10) ? 4'h1 : 4'h0));
        end

        // Two bits change in the same cycle and pulse together.
        a_in = 4'h5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("simul_k%0d", k), pk(a_out, a_rise, a_fall),
                  pk((k >= 6) ? 4'h5 : 4'h0, (k == 6) ? 4'h5 : 4'h0, 4'h0));
        end

        // Bypass with STAGES=3: bit 2 follows with a 3-edge lag.
        b_in = 4'h4;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 10) b_in = 4'h0;
            if (k == 20) b_in = 4'h4;
            check($sformatf("bypass_k%0d", k), pk(b_out, b_rise, b_fall),
                  pk(((k >= 3 && k <= 12) || k >= 23) ? 4'h4 : 4'h0,
                     (k == 3 || k == 23) ? 4'h4 : 4'h0,
                     (k == 13) ? 4'h4 : 4'h0));
        end

        // Reset while the counter is at 3 of 4: the output returns to
        // DEFAULT immediately and the pending change is discarded.
        a_in = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("midfilt_k%0d", k), pk(a_out, a_rise, a_fall), pk(4'h5, 4'h0, 4'h0));
        end
        #2 rst_n = 1'b0;
        #1;
        check("midfilt_async_clear", pk(a_out, a_rise, a_fall), pk(4'h0, 4'h0, 4'h0));
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("post_rst_k%0d", k), pk(a_out, a_rise, a_fall), pk(4'h0, 4'h0, 4'h0));
        end

`ifdef SYNC_FILTER_STICKY_EN
        // A rise on bit 1 sets the sticky flag, and the flag holds.
        check("sticky_reset", {28'h0, a_sticky}, 32'h0);
        a_in = 4'h2;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("sticky_set_k%0d", k), {28'h0, a_sticky},
                  (k >= 6) ? 32'h2 : 32'h0);
        end
        // A clear sampled on the same edge as a new fall: set wins.
        a_in = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) a_clr = 4'h2;
            check($sformatf("sticky_fall_k%0d", k), {24'h0, a_fall, a_sticky},
                  {24'h0, (k == 6) ? 4'h2 : 4'h0, 4'h2});
        end
        a_clr = 4'h0;
        tick();
        check("sticky_held", {28'h0, a_sticky}, 32'h2);
        a_clr = 4'h2;
        tick();
        a_clr = 4'h0;
        check("sticky_cleared", {28'h0, a_sticky}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sync_filter

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Parametrised successor to the plain two-flop synchroniser.
- Brings a WIDTH-bit bundle of independent asynchronous inputs into the i_clk domain through a configurable-depth flop chain.
- Optionally applies a per-bit stability (glitch) filter.
- Emits registered single-cycle rise and fall pulses per bit.
- Used for pins, buttons and slow cross-domain status flags feeding CSRs and interrupt logic.

Parameters:
- WIDTH, 1, number of independent bits.
- STAGES, 2, synchroniser flop depth; must be >= 2, otherwise elaboration error.
- DEFAULT, 0, WIDTH-bit reset value of the chain and of o_out.
- FILTER_CYCLES, 0, consecutive stable samples required before o_out commits a change; 0 bypasses the filter.

Ports:
- i_clk  input  1  sole clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_in  input  WIDTH  asynchronous inputs.
- o_out  output  WIDTH  synchronised, filtered level.
- o_rise  output  WIDTH  one-cycle pulse per bit when o_out goes 0->1.
- o_fall  output  WIDTH  one-cycle pulse per bit when o_out goes 1->0.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. All flops clear immediately on i_rst_n falling; no clock is required.
- Reset values:
  - Chain stages = DEFAULT; o_out = DEFAULT.
  - Filter counters = 0.
  - o_rise = o_fall = 0.
- Chain: stage[0] <= i_in; stage[k] <= stage[k-1]. Let s = stage[STAGES-1].
- FILTER_CYCLES = 0:
  - o_out is s itself.
  - Latency is STAGES rising edges from the first edge that samples the new i_in value (STAGES=2 matches the legacy synchroniser).
- FILTER_CYCLES = N >= 1, per-bit counter of width CNT_W = max(1, clog2(N+1)):
  - If s[i] == o_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == N-1: o_out[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - A change commits after s differs for N consecutive edges.
  - Total latency is STAGES + N edges.
  - Any excursion of s shorter than N samples is fully suppressed and the counter restarts at 0.
- Edge pulses:
  - Registered in the same edge that updates o_out: o_rise[i] = 1 exactly in the cycle where o_out[i] first reads 1 after reading 0; o_fall likewise.
  - Pulses last one cycle.
  - Bits are fully independent; simultaneous edges on multiple bits produce simultaneous pulses.
- Reset release:
  - No pulse is generated by reset assertion or release, even if DEFAULT differs from i_in.
  - The first change after release is a normal filtered transition (pulse fires).
- Reset mid-filter: counters are discarded; no partial transition survives reset.
- Counter never exceeds N-1, so no wrap-around is possible.

Optional Feature:
- Macro: SYNC_FILTER_STICKY_EN.
- When defined, adds ports i_sticky_clr input WIDTH and o_sticky output WIDTH.
  - o_sticky[i] sets on the edge where o_rise[i] or o_fall[i] is asserted.
  - It holds until i_sticky_clr[i] = 1 is sampled.
  - Set wins over clear in the same cycle.
  - Reset value is 0.
- When undefined, those ports and flops do not exist; all other behaviour is unchanged.

Decomposition:
- Package sync_filter_pkg holds:
  - function cnt_width(filter_cycles), returning max(1, clog2(filter_cycles+1));
  - localparam MIN_STAGES = 2.
- Sub-module sync_filter_bit: one bit's chain, counter, o_out flop, pulses and optional sticky flop.
- Top level instantiates sync_filter_bit WIDTH times in a generate loop, with DEFAULT[i] passed per bit.

Test Plan:
- Reset and startup: WIDTH=4, STAGES=2, N=4, DEFAULT=0, i_in=4'hF held through reset.
  - During reset: o_out=0, o_rise=o_fall=0.
  - After release: o_out=4'hF at the 6th edge after release, o_rise=4'hF for exactly one cycle, never o_fall.
- Glitch rejection, N=4: i_in[0] high for 3 cycles then low -> o_out[0] stays 0, no pulses. Repeat with 4 cycles high -> o_out[0] rises 6 edges after first sampling, one o_rise[0]; the later fall yields one o_fall[0].
- Bypass, N=0, STAGES=3: toggle i_in[2] every 10 cycles -> o_out[2] follows with a 3-edge lag, with one rise/fall pulse per transition.
- Simultaneous bits: i_in 4'h0->4'h5 in one cycle -> o_rise=4'h5 in a single cycle, o_fall=0.
- Async reset mid-filter: counter at 3 of 4, assert i_rst_n between edges -> o_out returns to DEFAULT immediately. After release with i_in stable at DEFAULT, no pulses for 20 cycles.
- SYNC_FILTER_STICKY_EN:
  - A rise on bit1 -> o_sticky=4'h2, held.
  - i_sticky_clr=4'h2 in the same cycle as a new bit1 edge -> sticky remains 1.
  - A later clear alone -> 0.
